uart_char_packetizer: RTL and testbench
=======================================

// Module: uart_char_packetizer
// PURPOSE
// - Sits between the UART receive character stream (from char2uart) and the tile NoC output.
// - Buffers received characters and emits them as multi-flit NoC packets: one header flit,
//   then one payload flit per character.
// - Flushes a packet when MAX_CHARS characters are buffered or the line has been idle for
//   FLUSH_TIMEOUT cycles.
// - Replaces the one-character-per-packet path, cutting header overhead for bulk console traffic.
// PARAMETERS
// - ph_dest_width  5       header destination field width
// - ph_cls_width   3       header class field width
// - ph_src_width   5       header source field width
// - destination    0       destination tile id written into the header
// - pkt_class      0       packet class written into the header
// - ID             0       own tile id, written as the header source
// - FIFO_DEPTH     16      character buffer depth; power of 2, >= MAX_CHARS
// - MAX_CHARS      8       maximum payload flits per packet, 1..FIFO_DEPTH
// - FLUSH_TIMEOUT  1024    idle cycles before a partial buffer is flushed, >= 1
// PORTS
// - clk        in   1    clock; single clock domain
// - rst        in   1    reset, asynchronous, active-high
// - char_data  in   8    received character
// - char_valid in   1    character valid
// - char_ready out  1    character accepted when char_valid & char_ready
// - noc_flit   out  34   {type[33:32], data[31:0]}
// - noc_valid  out  1    flit valid
// - noc_ready  in   1    flit accepted when noc_valid & noc_ready
// BEHAVIOUR
// - Reset (async, rst=1):
//   - FIFO empty, FSM IDLE, timer 0, flush_req 0.
//   - char_ready=0 while rst is high; noc_valid=0; noc_flit=0.
// - char_ready = ~fifo_full. It is registered-state only and never depends on the same-cycle pop.
// - Flit types: 2'b01 header, 2'b00 payload, 2'b10 last. Type 2'b11 is never emitted,
//   because every packet carries >= 1 character.
// - Header data layout:
//   - [31 -: ph_dest_width] = destination
//   - next ph_cls_width bits = pkt_class
//   - next ph_src_width bits = ID
//   - all remaining bits 0
// - Payload data = {24'h0, char}.
// - Idle timer (IDLE state only):
//   - Clears on any accepted character and whenever the FIFO is empty.
//   - Otherwise increments and saturates at FLUSH_TIMEOUT.
// - FSM states:
//   - IDLE -> HEADER when count >= MAX_CHARS, or count > 0 & timer == FLUSH_TIMEOUT,
//     or count > 0 & flush_req.
//     On this transition latch len = min(count, MAX_CHARS), clear the timer, and clear flush_req.
//   - HEADER: noc_valid=1, header flit. On noc_ready -> PAYLOAD.
//   - PAYLOAD: noc_valid=1, flit = FIFO head.
//     - Type is 2'b10 when the remaining count reaches 1, else 2'b00.
//     - Each handshake pops one character and decrements the remaining count.
//     - After the last flit -> IDLE.
// - Latency: with noc_ready held high, a full-trigger packet presents its header the cycle
//   after the IDLE->HEADER decision. Flits then stream one per cycle; there are no bubbles
//   inside a packet.
// - noc_valid, once asserted, stays high and noc_flit stays stable until noc_ready.
//   Backpressure never drops or reorders flits.
// - Characters arriving during HEADER/PAYLOAD are pushed normally.
//   - They never enter the packet in flight, because len is latched at packet start.
// - Simultaneous push and pop: both take effect and the count is unchanged. The FIFO pointers
//   wrap modulo FIFO_DEPTH.
// - FIFO full: char_ready=0. The upstream source holds its character. The packet drains
//   independently.
// - Reset mid-packet: the packet is aborted, buffered characters are discarded, and noc_valid
//   drops asynchronously. Downstream must tolerate the truncated packet.
// CONFIGURATION
// - OPTIMSOC_UART_NEWLINE_FLUSH_EN defined:
//   - Accepting char 8'h0A sets flush_req. This also applies during HEADER/PAYLOAD; the flag
//     is consumed at the next packet start.
//   - Result: lines are sent as soon as '\n' arrives, without waiting for FLUSH_TIMEOUT.
// - Macro undefined: flush_req is tied to 0, and only the full/timeout triggers apply.
// TESTING
// 1. Burst 'A'..'H' (8 chars, back-to-back), noc_ready=1 -> header, then 41..47 type 00,
//    then 48 type 10. Flits are consecutive and the timer is unused.
// 2. Send 3 chars "abc", then idle -> no flit before FLUSH_TIMEOUT idle cycles. Then the
//    packet is header + 61, 62 (type 00) + 63 (type 10).
// 3. noc_ready=0 while 20 chars are offered -> char_ready falls after 16 accepted. Raising
//    noc_ready yields two 8-char packets. The remaining 4 flush after the timeout, and every
//    character is delivered in order.
// 4. noc_ready toggling randomly during a packet -> noc_flit is stable while noc_valid & ~noc_ready,
//    and there is exactly one type-10 flit per header.
// 5. NEWLINE_FLUSH_EN: send "hi\n" -> the packet starts within 2 cycles of accepting 0A and is
//    header, 68, 69, 0A (last). Without the macro, the same packet appears only after the timeout.
// 6. Assert rst during PAYLOAD -> noc_valid=0 immediately. After release the FIFO is empty,
//    and a new 1-char packet after the timeout is header + single type-10 flit.

Source files
------------

// File: rtl/uart_char_packetizer.sv
// Packs the UART receive character stream into NoC packets: header flit plus one flit per char.
// Optional OPTIMSOC_UART_NEWLINE_FLUSH_EN: an accepted '\n' requests an early flush.
module uart_char_packetizer #(
    parameter int unsigned ph_dest_width = 5,
    parameter int unsigned ph_cls_width  = 3,
    parameter int unsigned ph_src_width  = 5,
    parameter int unsigned destination   = 0,
    parameter int unsigned pkt_class     = 0,
    parameter int unsigned ID            = 0,
    parameter int unsigned FIFO_DEPTH    = 16,
    parameter int unsigned MAX_CHARS     = 8,
    parameter int unsigned FLUSH_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  char_data,
    input  logic        char_valid,
    output logic        char_ready,
    output logic [33:0] noc_flit,
    output logic        noc_valid,
    input  logic        noc_ready
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = $clog2(FLUSH_TIMEOUT + 1);
    localparam logic [CW-1:0] MaxCnt     = CW'(MAX_CHARS);
    localparam logic [CW-1:0] FullCnt    = CW'(FIFO_DEPTH);
    localparam logic [TW-1:0] TimeoutVal = TW'(FLUSH_TIMEOUT);
    localparam logic [1:0] TypePayload = 2'b00;
    localparam logic [1:0] TypeHeader  = 2'b01;
    localparam logic [1:0] TypeLast    = 2'b10;

    typedef enum logic [1:0] {StIdle, StHeader, StPayload} state_e;

    state_e        state;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, remaining;
    logic [TW-1:0] timer;
    logic          flush_req;
    logic [31:0]   header_data;
    logic          push, pop, start;

    always_comb begin
        header_data = '0;
        header_data[31 -: ph_dest_width] = destination[ph_dest_width-1:0];
        header_data[31-ph_dest_width -: ph_cls_width] = pkt_class[ph_cls_width-1:0];
        header_data[31-ph_dest_width-ph_cls_width -: ph_src_width] = ID[ph_src_width-1:0];
    end

    // Ready depends only on registered occupancy, never on a same-cycle pop.
    assign char_ready = ~rst & (count != FullCnt);
    assign push       = char_valid & char_ready;
    assign pop        = (state == StPayload) & noc_ready;
    assign start      = (state == StIdle) &
                        ((count >= MaxCnt) ||
                         ((count != '0) && ((timer == TimeoutVal) || flush_req)));

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= char_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= StIdle;
            remaining <= '0;
            timer     <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (start) begin
                        state     <= StHeader;
                        remaining <= (count >= MaxCnt) ? MaxCnt : count;
                        timer     <= '0;
                    end else if (push || count == '0) begin
                        timer <= '0;
                    end else if (timer != TimeoutVal) begin
                        timer <= timer + 1'b1;
                    end
                end
                StHeader: begin
                    if (noc_ready) state <= StPayload;
                end
                StPayload: begin
                    if (noc_ready) begin
                        remaining <= remaining - 1'b1;
                        if (remaining == CW'(1)) state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

`ifdef OPTIMSOC_UART_NEWLINE_FLUSH_EN
    // Set wins over clear so a newline arriving on the start cycle is not lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_req <= 1'b0;
        end else begin
            if (start) flush_req <= 1'b0;
            if (push && char_data == 8'h0A) flush_req <= 1'b1;
        end
    end
`else
    assign flush_req = 1'b0;
`endif

    always_comb begin
        noc_valid = 1'b0;
        noc_flit  = '0;
        unique case (state)
            StHeader: begin
                noc_valid = 1'b1;
                noc_flit  = {TypeHeader, header_data};
            end
            StPayload: begin
                noc_valid = 1'b1;
                noc_flit  = {(remaining == CW'(1)) ? TypeLast : TypePayload, 24'h0, mem[rd_ptr]};
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_uart_char_packetizer.sv
// Directed bench for uart_char_packetizer: bursts, timeout flush, backpressure, reset abort.
module tb_uart_char_packetizer;

    localparam int T = 40;
    localparam logic [33:0] Hdr = {2'b01, 32'h9D50_0000};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  char_data = '0;
    logic        char_valid = 1'b0;
    logic        char_ready;
    logic [33:0] noc_flit;
    logic        noc_valid;
    logic        noc_ready = 1'b1;

    int n_cmp = 0;
    int n_err = 0;

    uart_char_packetizer #(
        .destination  (19),
        .pkt_class    (5),
        .ID           (10),
        .FIFO_DEPTH   (16),
        .MAX_CHARS    (8),
        .FLUSH_TIMEOUT(T)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .char_data (char_data),
        .char_valid(char_valid),
        .char_ready(char_ready),
        .noc_flit  (noc_flit),
        .noc_valid (noc_valid),
        .noc_ready (noc_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed no completion, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [33:0] obs, input logic [33:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_char(input logic [7:0] c);
        int w;
        char_data  = c;
        char_valid = 1'b1;
        w = 0;
        while (!char_ready && w < 300) begin
            tick();
            w++;
        end
        check("send_ready", 34'(char_ready), 34'd1);
        tick();
        char_valid = 1'b0;
    endtask

    // Waits up to budget cycles for a flit, checks it, and consumes it (noc_ready must be 1).
    task automatic expect_flit(input string tag, input logic [33:0] exp, input int budget,
                               output int waited);
        waited = 0;
        while (!noc_valid && waited < budget) begin
            tick();
            waited++;
        end
        check({tag, "_valid"}, 34'(noc_valid), 34'd1);
        check(tag, noc_flit, exp);
        if (noc_valid) tick();
    endtask

    function automatic logic [33:0] pl(input logic [7:0] c, input logic last);
        return {last ? 2'b10 : 2'b00, 24'h0, c};
    endfunction

    initial begin
        int w;
        int acc;
        int idx;
        int lasts;
        int hdrs;
        int highs;
        logic rdy_seen;
        logic [15:0] pat;
        logic [33:0] exp4 [9];
        logic [7:0] s [3];

        // Reset state
        #1;
        check("rst_char_ready", 34'(char_ready), 34'd0);
        check("rst_noc_valid", 34'(noc_valid), 34'd0);
        check("rst_noc_flit", noc_flit, 34'd0);
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_ready", 34'(char_ready), 34'd1);

        // 1: full-trigger burst, header one cycle after the last push, no bubbles
        for (int i = 0; i < 8; i++) send_char(8'h41 + 8'(i));
        expect_flit("t1_hdr", Hdr, 4, w);
        check("t1_hdr_latency", 34'(w), 34'd1);
        for (int i = 0; i < 8; i++) expect_flit("t1_pl", pl(8'h41 + 8'(i), i == 7), 0, w);
        check("t1_idle_after", 34'(noc_valid), 34'd0);

        // 2: partial buffer flushes exactly after the idle timeout
        s[0] = 8'h61; s[1] = 8'h62; s[2] = 8'h63;
        for (int i = 0; i < 3; i++) send_char(s[i]);
        expect_flit("t2_hdr", Hdr, T + 10, w);
        check("t2_timeout_latency", 34'(w), 34'(T + 1));
        for (int i = 0; i < 3; i++) expect_flit("t2_pl", pl(s[i], i == 2), 0, w);

        // 3: backpressure fills the FIFO, then drains as 8 + 8 + 4 in order
        noc_ready = 1'b0;
        acc = 0;
        for (int k = 0; k < 25; k++) begin
            char_data  = 8'h30 + 8'(acc);
            char_valid = (acc < 20);
            rdy_seen   = char_ready;
            tick();
            if (rdy_seen && char_valid) acc++;
        end
        char_valid = 1'b0;
        check("t3_accepted", 34'(acc), 34'd16);
        check("t3_full_ready", 34'(char_ready), 34'd0);
        check("t3_stalled_hdr", noc_flit, Hdr);
        fork
            begin
                for (int i = 16; i < 20; i++) send_char(8'h30 + 8'(i));
            end
            begin
                int wb;
                noc_ready = 1'b1;
                expect_flit("t3_hdr1", Hdr, 0, wb);
                for (int i = 0; i < 8; i++) expect_flit("t3_p1", pl(8'h30 + 8'(i), i == 7), 0, wb);
                expect_flit("t3_hdr2", Hdr, 10, wb);
                for (int i = 8; i < 16; i++) expect_flit("t3_p2", pl(8'h30 + 8'(i), i == 15), 0, wb);
                expect_flit("t3_hdr3", Hdr, T + 20, wb);
                for (int i = 16; i < 20; i++) expect_flit("t3_p3", pl(8'h30 + 8'(i), i == 19), 0, wb);
            end
        join

        // 4: random-looking noc_ready pattern; flit must hold its expected value while stalled
        noc_ready = 1'b0;
        for (int i = 0; i < 8; i++) send_char(8'h50 + 8'(i));
        exp4[0] = Hdr;
        for (int i = 0; i < 8; i++) exp4[i+1] = pl(8'h50 + 8'(i), i == 7);
        pat = 16'b0110_1001_1100_1010;
        idx = 0; lasts = 0; hdrs = 0;
        for (int k = 0; k < 80 && idx < 9; k++) begin
            noc_ready = pat[k % 16];
            if (noc_valid) begin
                check("t4_flit", noc_flit, exp4[idx]);
                if (noc_ready) begin
                    if (noc_flit[33:32] == 2'b10) lasts++;
                    if (noc_flit[33:32] == 2'b01) hdrs++;
                    idx++;
                end
            end
            tick();
        end
        noc_ready = 1'b1;
        check("t4_delivered", 34'(idx), 34'd9);
        check("t4_last_count", 34'(lasts), 34'd1);
        check("t4_hdr_count", 34'(hdrs), 34'd1);

        // 5: "hi\n"
        s[0] = 8'h68; s[1] = 8'h69; s[2] = 8'h0A;
        for (int i = 0; i < 3; i++) send_char(s[i]);
        expect_flit("t5_hdr", Hdr, T + 10, w);
`ifdef OPTIMSOC_UART_NEWLINE_FLUSH_EN
        check("t5_latency", 34'(w), 34'd1);
`else
        check("t5_latency", 34'(w), 34'(T + 1));
`endif
        for (int i = 0; i < 3; i++) expect_flit("t5_pl", pl(s[i], i == 2), 0, w);

        // 6: reset during payload aborts the packet and empties the FIFO
        for (int i = 0; i < 8; i++) send_char(8'h70 + 8'(i));
        expect_flit("t6_hdr", Hdr, 4, w);
        expect_flit("t6_pl0", pl(8'h70, 1'b0), 0, w);
        noc_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_valid", 34'(noc_valid), 34'd0);
        check("t6_rst_flit", noc_flit, 34'd0);
        check("t6_rst_ready", 34'(char_ready), 34'd0);
        tick();
        rst = 1'b0;
        noc_ready = 1'b1;
        highs = 0;
        for (int k = 0; k < T + 10; k++) begin
            if (noc_valid) highs++;
            tick();
        end
        check("t6_empty_after_rst", 34'(highs), 34'd0);
        check("t6_ready_after_rst", 34'(char_ready), 34'd1);
        send_char(8'h7A);
        expect_flit("t6_hdr2", Hdr, T + 10, w);
        check("t6_latency", 34'(w), 34'(T + 1));
        expect_flit("t6_single", pl(8'h7A, 1'b1), 0, w);
        check("t6_idle_end", 34'(noc_valid), 34'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
